// File: rtl/sha256_round_ctrl.sv
// sha256_round_ctrl
//   Sequencer for sha256_hash_core. Takes one pre-padded 512-bit block as
//   16 big-endian 32-bit words. It expands the message schedule in a
//   16-entry circular buffer and feeds Wt/Kt to the core for 64 rounds.
//   It then adds the IV to the core's working state and presents the
//   digest on a valid/ready output.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   abort_i         synchronous abort, returns to IDLE from any state
//   msg_valid_i     message word stream (first word is W[0])
//   msg_ready_o
//   msg_word_i
//   core_ld_o       core IV load (IDLE/LOAD)
//   core_en_o       core round enable (ROUND)
//   core_wt_o       W[t] / K[t] for the current round
//   core_kt_o
//   core_state_i    {A,B,C,D,E,F,G,H} from the core
//   digest_o        {H0..H7}, H0 in [255:224]
//   digest_valid_o  digest output stream
//   digest_ready_i
//   busy_o          high in every state except IDLE
module sha256_round_ctrl #(
  parameter logic [255:0] H_INIT = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         abort_i,
  input  logic         msg_valid_i,
  output logic         msg_ready_o,
  input  logic [31:0]  msg_word_i,
  output logic         core_ld_o,
  output logic         core_en_o,
  output logic [31:0]  core_wt_o,
  output logic [31:0]  core_kt_o,
  input  logic [255:0] core_state_i,
  output logic [255:0] digest_o,
  output logic         digest_valid_o,
  input  logic         digest_ready_i,
  output logic         busy_o
);

  typedef enum logic [2:0] {IDLE, LOAD, ROUND, FINAL, OUT} state_t;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

  state_t        state, state_nxt;
  logic [3:0]    cnt;
  logic [5:0]    t;
  logic [31:0]   w_buf [16];
  logic [31:0]   w_sched;
  logic [3:0]    idx2, idx7, idx15;
  logic [255:0]  digest_sum;
  logic          msg_hs;

  // Buffer indices wrap naturally in 4 bits, so slot t&15 still holds W[t-16]
  assign idx2    = t[3:0] - 4'd2;
  assign idx7    = t[3:0] - 4'd7;
  assign idx15   = t[3:0] - 4'd15;
  assign w_sched = ssig1(w_buf[idx2]) + w_buf[idx7] + ssig0(w_buf[idx15]) + w_buf[t[3:0]];

  assign msg_ready_o = ((state == IDLE) || (state == LOAD)) && !abort_i;
  assign msg_hs      = msg_valid_i && msg_ready_o;

  always_comb begin
    digest_sum = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      digest_sum[32*i +: 32] = H_INIT[32*i +: 32] + core_state_i[32*i +: 32];
    end
  end

  always_comb begin
    state_nxt      = state;
    core_ld_o      = 1'b0;
    core_en_o      = 1'b0;
    core_wt_o      = '0;
    core_kt_o      = '0;
    digest_valid_o = 1'b0;
    busy_o         = (state != IDLE);
    case (state)
      IDLE: begin
        core_ld_o = 1'b1;
        if (msg_hs) state_nxt = LOAD;
      end
      LOAD: begin
        core_ld_o = 1'b1;
        if (msg_hs && (cnt == 4'd15)) state_nxt = ROUND;
      end
      ROUND: begin
        core_en_o = 1'b1;
        core_kt_o = K_TAB[t];
        core_wt_o = (t[5:4] == 2'b00) ? w_buf[t[3:0]] : w_sched;
        if (t == 6'd63) state_nxt = FINAL;
      end
      FINAL: state_nxt = OUT;
      OUT: begin
        digest_valid_o = 1'b1;
        if (digest_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_i) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      t        <= '0;
      digest_o <= '0;
      for (int unsigned i = 0; i < 16; i++) w_buf[i] <= '0;
    end else begin
      state <= state_nxt;
      if (abort_i) begin
        cnt <= '0;
        t   <= '0;
      end else begin
        case (state)
          IDLE: if (msg_hs) begin
            w_buf[0] <= msg_word_i;
            cnt      <= 4'd1;
          end
          LOAD: if (msg_hs) begin
            w_buf[cnt] <= msg_word_i;
            cnt        <= cnt + 4'd1;
            if (cnt == 4'd15) t <= '0;
          end
          ROUND: begin
            // Expanded word replaces W[t-16], which is no longer needed
            if (t[5:4] != 2'b00) w_buf[t[3:0]] <= w_sched;
            t <= t + 6'd1;
          end
          FINAL: digest_o <= digest_sum;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// tb_sha256_round_ctrl
//   Directed bench for sha256_round_ctrl, with a behavioural sha256 core
//   closing the loop. Expected digests are the known SHA-256 results.
module tb_sha256_round_ctrl;

  localparam logic [255:0] IV        = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         abort;
  logic         msg_valid;
  logic         msg_ready;
  logic [31:0]  msg_word;
  logic         core_ld;
  logic         core_en;
  logic [31:0]  core_wt;
  logic [31:0]  core_kt;
  logic [255:0] core_state;
  logic [255:0] digest;
  logic         digest_valid;
  logic         digest_ready;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sha256_round_ctrl #(.H_INIT(IV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .abort_i        (abort),
    .msg_valid_i    (msg_valid),
    .msg_ready_o    (msg_ready),
    .msg_word_i     (msg_word),
    .core_ld_o      (core_ld),
    .core_en_o      (core_en),
    .core_wt_o      (core_wt),
    .core_kt_o      (core_kt),
    .core_state_i   (core_state),
    .digest_o       (digest),
    .digest_valid_o (digest_valid),
    .digest_ready_i (digest_ready),
    .busy_o         (busy)
  );

  // Behavioural compression core
  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] core_round(input logic [255:0] s, input logic [31:0] w, input logic [31:0] k);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       core_state <= IV;
    else if (core_ld) core_state <= IV;
    else if (core_en) core_state <= core_round(core_state, core_wt, core_kt);
  end

  // Output monitor
  logic [255:0] dq [$];
  int           rq [$];
  int           en_total = 0;
  int           vrise_total = 0;
  int           last_rise = 0;
  logic         prev_v = 1'b0;

  always @(negedge clk) begin
    if (core_en) en_total <= en_total + 1;
    if (digest_valid && !prev_v) begin
      vrise_total <= vrise_total + 1;
      last_rise   <= cyc;
    end
    if (digest_valid && digest_ready) begin
      dq.push_back(digest);
      rq.push_back((!prev_v) ? cyc : last_rise);
    end
    prev_v <= digest_valid;
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_msg_ready"}, 256'(msg_ready), 256'(1));
    chk({tag, "_core_ld"}, 256'(core_ld), 256'(1));
    chk({tag, "_busy"}, 256'(busy), 256'(0));
    chk({tag, "_digest_valid"}, 256'(digest_valid), 256'(0));
    chk({tag, "_digest"}, digest, 256'(0));
    chk({tag, "_core_en"}, 256'(core_en), 256'(0));
    chk({tag, "_core_wt"}, 256'(core_wt), 256'(0));
    chk({tag, "_core_kt"}, 256'(core_kt), 256'(0));
  endtask

  // Sends the first n words of w; returns cycles of the first and last accept
  task automatic send_words(input logic [31:0] w [16], input int n, input bit bubbles,
                            output int first_c, output int last_c);
    int  waited;
    bit  got;
    int  gap;
    first_c = -1;
    last_c  = -1;
    for (int i = 0; i < n; i++) begin
      if (bubbles) begin
        gap = int'($urandom_range(0, 3));
        repeat (gap) begin
          msg_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      msg_valid = 1'b1;
      msg_word  = w[i];
      waited = 0;
      got    = 1'b0;
      while (!got && waited < 200) begin
        @(negedge clk);
        if (msg_ready) begin
          got = 1'b1;
          if (i == 0) first_c = cyc;
          last_c = cyc;
        end
        @(posedge clk); #1;
        waited++;
      end
      if (!got) begin
        chk("send_timeout", 256'(0), 256'(1));
        msg_valid = 1'b0;
        return;
      end
    end
    msg_valid = 1'b0;
  endtask

  task automatic get_digest(output logic [255:0] d, output int rc);
    int waited = 0;
    d  = '0;
    rc = -1;
    while (dq.size() == 0 && waited < 400) begin
      @(posedge clk); #1;
      waited++;
    end
    if (dq.size() == 0) begin
      chk("digest_timeout", 256'(0), 256'(1));
      return;
    end
    d  = dq.pop_front();
    rc = rq.pop_front();
  endtask

  logic [31:0]  abc_w   [16];
  logic [31:0]  empty_w [16];
  logic [255:0] d;
  int           rc, fa, la, fb, lb, en0, vr0, waited;

  initial begin
    for (int i = 0; i < 16; i++) begin
      abc_w[i]   = '0;
      empty_w[i] = '0;
    end
    abc_w[0]   = 32'h61626380;
    abc_w[15]  = 32'h00000018;
    empty_w[0] = 32'h80000000;

    rst_n = 1'b0; abort = 1'b0; msg_valid = 1'b0; msg_word = '0; digest_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: "abc" with latency
    en0 = en_total;
    send_words(abc_w, 16, 1'b0, fa, la);
    get_digest(d, rc);
    chk("abc_digest", d, DIG_ABC);
    chk("abc_latency", 256'(rc - la), 256'(66));
    chk("abc_en_cycles", 256'(en_total - en0), 256'(64));

    // 2: empty message
    send_words(empty_w, 16, 1'b0, fa, la);
    get_digest(d, rc);
    chk("empty_digest", d, DIG_EMPTY);

    // 3: bubbles during load, output held for 20 cycles
    digest_ready = 1'b0;
    en0 = en_total;
    send_words(abc_w, 16, 1'b1, fa, la);
    waited = 0;
    @(negedge clk);
    while (!digest_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("hold_valid_seen", 256'(digest_valid), 256'(1));
    for (int i = 0; i < 20; i++) begin
      chk("hold_digest", digest, DIG_ABC);
      @(negedge clk);
    end
    chk("hold_valid_end", 256'(digest_valid), 256'(1));
    @(posedge clk); #1;
    digest_ready = 1'b1;
    get_digest(d, rc);
    chk("hold_handshake_digest", d, DIG_ABC);
    chk("hold_en_cycles", 256'(en_total - en0), 256'(64));
    @(negedge clk);
    chk("hold_valid_drop", 256'(digest_valid), 256'(0));
    @(posedge clk); #1;

    // 4: back-to-back blocks, ready tied high
    send_words(abc_w, 16, 1'b0, fa, la);
    send_words(empty_w, 16, 1'b0, fb, lb);
    chk("b2b_first_word", 256'(fb - la), 256'(67));
    get_digest(d, rc);
    chk("b2b_digest_abc", d, DIG_ABC);
    get_digest(d, rc);
    chk("b2b_digest_empty", d, DIG_EMPTY);

    // 5: abort at round t=30
    vr0 = vrise_total;
    send_words(abc_w, 16, 1'b0, fa, la);
    repeat (30) @(posedge clk);
    #1;
    chk("abort_busy_before", 256'(busy), 256'(1));
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy_after", 256'(busy), 256'(0));
    abort = 1'b1;
    msg_valid = 1'b1;
    msg_word = 32'hdeadbeef;
    #1;
    chk("abort_ready_forced", 256'(msg_ready), 256'(0));
    @(posedge clk); #1;
    abort = 1'b0;
    msg_valid = 1'b0;
    chk("abort_word_ignored", 256'(busy), 256'(0));
    repeat (80) @(posedge clk);
    #1;
    chk("abort_no_digest", 256'(vrise_total - vr0), 256'(0));
    send_words(abc_w, 16, 1'b0, fa, la);
    get_digest(d, rc);
    chk("abort_then_abc", d, DIG_ABC);

    // 6: reset during partial load
    send_words(abc_w, 9, 1'b0, fa, la);
    rst_n = 1'b0;
    #1;
    check_reset_vals("midload_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_words(abc_w, 16, 1'b0, fa, la);
    get_digest(d, rc);
    chk("rst_then_abc", d, DIG_ABC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/sha256_round_ctrl.md
Name: sha256_round_ctrl

Overview:
Sequencer for sha256_hash_core. Accepts one pre-padded 512-bit message block as 16 big-endian 32-bit words over a valid/ready stream. Generates the message schedule W[0..63] in a 16-entry circular buffer and supplies K[t], driving the core's ld_i/en_i for 64 rounds. Performs the final IV + working-state addition and presents the 256-bit digest on a valid/ready output. Single-block messages only; the core has no chaining-value load path.

Parameters:
H_INIT, 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19, IV added to the final core state as {H0..H7}; must equal the core's load values.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
abort_i  in  1  synchronous abort; returns to IDLE from any state
msg_valid_i  in  1  message word valid
msg_ready_o  out  1  message word accepted when valid & ready
msg_word_i  in  32  message word; first word is W[0]
core_ld_o  out  1  to core ld_i
core_en_o  out  1  to core en_i
core_wt_o  out  32  to core Wt_i
core_kt_o  out  32  to core Kt_i
core_state_i  in  256  {A_o,B_o,C_o,D_o,E_o,F_o,G_o,H_o} from core
digest_o  out  256  {H0..H7}, H0 in [255:224]
digest_valid_o  out  1  digest valid
digest_ready_i  in  1  digest consumed when valid & ready
busy_o  out  1  high in every state except IDLE

Behaviour:
- FSM states: IDLE, LOAD, ROUND, FINAL, OUT. Word counter is 4 bits; round counter t is 6 bits.
- Reset values: state IDLE, all counters and W buffer 0, digest_o 0, digest_valid_o 0, core_en_o 0, core_wt_o 0, core_kt_o 0, busy_o 0. msg_ready_o and core_ld_o are 1 because both are decoded from IDLE.
- msg_ready_o = 1 in IDLE and LOAD only. core_ld_o = 1 in IDLE and LOAD only; the core reloads the IV continuously before rounds start.
- IDLE: a word handshake writes buf[0], sets the word counter to 1, and moves to LOAD.
- LOAD: each handshake writes buf[cnt] and increments cnt. Bubbles (msg_valid_i low) are allowed and wait indefinitely. The handshake with cnt=15 moves to ROUND with t=0.
- ROUND: core_en_o = 1, core_kt_o = K[t] (64-entry FIPS 180-4 constant table).
  - For t<16, core_wt_o = buf[t].
  - For t>=16, core_wt_o = ssig1(buf[(t-2)&15]) + buf[(t-7)&15] + ssig0(buf[(t-15)&15]) + buf[t&15].
    - ssig0(x) = rotr7 ^ rotr18 ^ shr3.
    - ssig1(x) = rotr17 ^ rotr19 ^ shr10.
    - Sums are mod 2^32, computed combinationally.
    - The result is written into buf[t&15] at the same clock edge.
  - t increments each cycle. At t=63 the state moves to FINAL.
- Outside ROUND: core_en_o = 0, core_wt_o = 0, core_kt_o = 0.
- FINAL (1 cycle): the core is idle (ld=0, en=0). digest_o <= per-word (H_INIT[i] + core_state_i[i]) mod 2^32. Moves to OUT.
- OUT: digest_valid_o = 1 and digest_o is held stable until digest_ready_i. On the handshake, digest_valid_o drops next cycle and the state moves to IDLE. digest_o keeps its last value until the next FINAL.
- Latency: last word accepted in cycle N, rounds in cycles N+1..N+64, FINAL in N+65, digest_valid_o high from N+66. If ready is high at the first valid cycle, the next block's first word can be accepted in N+67 at the earliest.
- abort_i has priority over all transitions:
  - next state IDLE; counters cleared; digest_valid_o cleared;
  - a word presented in the abort cycle is not accepted (msg_ready_o is forced 0 when abort_i = 1);
  - buf contents are don't-care.
- rst_n asserted in any state forces the reset values asynchronously. A partially loaded block is discarded.
- msg_valid_i while busy in ROUND/FINAL/OUT is ignored (not accepted, no stall of rounds).

Test Plan:
1. "abc" block: 61626380, 14×00000000, 00000018 → digest ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad. digest_valid_o rises exactly 66 cycles after the last word.
2. Empty message: 80000000, 15×00000000 → e3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855.
3. Random msg_valid_i bubbles during LOAD plus digest_ready_i held low 20 cycles:
   - the "abc" digest is unchanged and stable throughout OUT;
   - core_en_o is high for exactly 64 cycles.
4. Back-to-back: abc then empty block with ready tied high → both digests correct; the second block's first word is accepted in cycle N+67.
5. abort_i pulsed at round t=30, then "abc" sent → busy_o drops next cycle, no digest_valid_o for the aborted block, and the "abc" digest is correct.
6. rst_n asserted after 9 words loaded, then released → all outputs at reset values, msg_ready_o = 1; a full "abc" block then yields the correct digest.
